wb_unit: RTL and testbench
==========================

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 Parameter XLEN, default 64, datapath width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4, load-result queue depth (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 alu_valid / alu_we  input  1 / 1  ALU-pipe result present / writes a register.
REQ-006 alu_data / alu_rd  input  XLEN / 5  ALU result and destination.
REQ-007 mem_valid  input  1  load result present.
REQ-008 mem_data / mem_rd  input  XLEN / 5  raw load data and destination.
REQ-009 mem_funct3 / mem_addr_lo  input  3 / 3  load type and byte offset.
REQ-010 mem_ready  output  1  combinational, high when fifo_count < FIFO_DEPTH.
REQ-011 check_rd  input  5  register probed by the hazard unit.
REQ-012 check_hit  output  1  combinational, high when any queued entry has rd == check_rd and check_rd != 0.
REQ-013 op_write / write_data / write_addr  output  1 / XLEN / 5  registered register-file write port.
REQ-014 fifo_count  output  log2(FIFO_DEPTH)+1  current queue occupancy.
REQ-015 overflow_err  output  1  sticky: load accepted while queue full.

Function
REQ-016 ALU results SHALL have strict priority on the write port; latency alu_valid -> op_write SHALL be exactly 1 cycle.
REQ-017 Results with rd == 0, or ALU results with alu_we == 0, SHALL be discarded: never queued, never written.
REQ-018 A load result SHALL bypass the queue and be written on the next edge when the queue is empty and no ALU write occurs that cycle.
REQ-019 Otherwise a load result SHALL be pushed to the queue tail, or the queue head SHALL be popped and written in any cycle without an ALU write; queue order is FIFO.
REQ-020 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-021 A load with mem_valid=1 while mem_ready=0 SHALL be dropped and SHALL set overflow_err, which stays set until reset.
REQ-022 In cycles with no write, op_write SHALL be 0 and write_data/write_addr SHALL hold their previous values.
REQ-023 check_hit SHALL be evaluated on current queue contents only, excluding the entry being written this cycle.
REQ-024 Load extension, when compiled in, SHALL be applied before enqueue or bypass; queued data is final register data.

Reset
REQ-025 While reset_n=0: op_write=0, write_data=0, write_addr=0, fifo_count=0, overflow_err=0, queue empty; any in-flight entries are lost.
REQ-026 Reset assertion mid-operation SHALL take effect immediately without waiting for clk; the first write is possible on the first edge after deassertion.

Configuration
REQ-027 Macro WB_LOAD_EXT_EN defined: data = mem_data >> (8*mem_addr_lo), then funct3 000 LB sign-extend byte, 001 LH sign-extend half, 010 LW sign-extend word, 011 LD unchanged, 100 LBU/101 LHU/110 LWU zero-extend, 111 pass unchanged.
REQ-028 Macro WB_LOAD_EXT_EN undefined: mem_data is written unmodified; mem_funct3 and mem_addr_lo remain ports and are ignored.

Verification
REQ-029 Reset then idle: op_write=0, write_data=0, mem_ready=1, fifo_count=0, overflow_err=0.
REQ-030 ALU write (alu_data=0x1234, rd=5) together with load (rd=7, data=0xAA) -> cycle+1: write rd5=0x1234, fifo_count=1; cycle+2: write rd7=0xAA, fifo_count=0.
REQ-031 Continuous ALU writes for 5 cycles with a load each cycle (FIFO_DEPTH=4) -> mem_ready low after 4 pushes; 5th load sets overflow_err=1; queue then drains in order rd values 1,2,3,4.
REQ-032 Load queued for rd=9 behind an ALU write -> check_hit=1 for check_rd=9, 0 for check_rd=0 and check_rd=8; check_hit drops after the drain write.
REQ-033 WB_LOAD_EXT_EN set: mem_data=0x00000000_0000F080, addr_lo=1, funct3=000 -> write_data=0xFFFFFFFF_FFFFFFF0; funct3=100 -> 0xF0; macro unset -> 0xF080.
REQ-034 Writes with rd=0, and alu_we=0 -> op_write stays 0 and fifo_count stays 0; reset_n pulsed low with 3 queued entries -> fifo_count=0 immediately, no writes follow.

Source files
------------

// File: rtl/wb_unit_if.sv
// rtl/wb_unit_if.sv - writeback unit bus: ALU/load result inputs, hazard probe, register-file write port
interface wb_unit_if #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            alu_valid;
    logic            alu_we;
    logic [XLEN-1:0] alu_data;
    logic [4:0]      alu_rd;
    logic            mem_valid;
    logic [XLEN-1:0] mem_data;
    logic [4:0]      mem_rd;
    logic [2:0]      mem_funct3;
    logic [2:0]      mem_addr_lo;
    logic            mem_ready;
    logic [4:0]      check_rd;
    logic            check_hit;
    logic            op_write;
    logic [XLEN-1:0] write_data;
    logic [4:0]      write_addr;
    logic [CW-1:0]   fifo_count;
    logic            overflow_err;

    modport master (
        output alu_valid, alu_we, alu_data, alu_rd,
        output mem_valid, mem_data, mem_rd, mem_funct3, mem_addr_lo,
        output check_rd,
        input  mem_ready, check_hit, op_write, write_data, write_addr,
        input  fifo_count, overflow_err
    );

    modport slave (
        input  alu_valid, alu_we, alu_data, alu_rd,
        input  mem_valid, mem_data, mem_rd, mem_funct3, mem_addr_lo,
        input  check_rd,
        output mem_ready, check_hit, op_write, write_data, write_addr,
        output fifo_count, overflow_err
    );
endinterface

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - writeback arbiter, ALU priority over a load-result FIFO; WB_LOAD_EXT_EN enables load extension
module wb_unit #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    wb_unit_if.slave   bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] q_data [FIFO_DEPTH];
    logic [4:0]      q_rd   [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            op_write_q;
    logic [XLEN-1:0] write_data_q;
    logic [4:0]      write_addr_q;
    logic            overflow_q;

    logic            alu_wr;
    logic            mem_ready;
    logic            load_ok;
    logic            empty;
    logic            pop;
    logic            bypass;
    logic            push;
    logic [XLEN-1:0] load_data;
    logic            hit;

`ifdef WB_LOAD_EXT_EN
    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = bus.mem_data >> {bus.mem_addr_lo, 3'b000};
        case (bus.mem_funct3)
            3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            3'b110:  load_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end
`else
    logic unused_load_fields;

    assign unused_load_fields = ^{bus.mem_funct3, bus.mem_addr_lo};
    assign load_data          = bus.mem_data;
`endif

    // Destination x0 is never written, so such results are simply ignored.
    assign alu_wr    = bus.alu_valid && bus.alu_we && (bus.alu_rd != 5'd0);
    assign mem_ready = (count < CW'(FIFO_DEPTH));
    assign load_ok   = bus.mem_valid && (bus.mem_rd != 5'd0) && mem_ready;
    assign empty     = (count == '0);
    assign pop       = !alu_wr && !empty;
    assign bypass    = !alu_wr && empty && load_ok;
    assign push      = load_ok && !bypass;

    // The head is excluded when it is being drained this cycle.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ((CW'(i) < count) && !((i == 0) && pop) &&
                (q_rd[rd_ptr + PW'(i)] == bus.check_rd))
                hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= load_data;
            q_rd[wr_ptr]   <= bus.mem_rd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_write_q   <= 1'b0;
            write_data_q <= '0;
            write_addr_q <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            overflow_q   <= 1'b0;
        end else begin
            op_write_q <= alu_wr || pop || bypass;
            if (alu_wr) begin
                write_data_q <= bus.alu_data;
                write_addr_q <= bus.alu_rd;
            end else if (pop) begin
                write_data_q <= q_data[rd_ptr];
                write_addr_q <= q_rd[rd_ptr];
            end else if (bypass) begin
                write_data_q <= load_data;
                write_addr_q <= bus.mem_rd;
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.mem_valid && !mem_ready)
                overflow_q <= 1'b1;
        end
    end

    assign bus.mem_ready    = mem_ready;
    assign bus.check_hit    = hit && (bus.check_rd != 5'd0);
    assign bus.op_write     = op_write_q;
    assign bus.write_data   = write_data_q;
    assign bus.write_addr   = write_addr_q;
    assign bus.fifo_count   = count;
    assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - directed and randomized checks of wb_unit against a queue-based reference model
module tb_wb_unit;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    wb_unit_if #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) bus ();

    wb_unit #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_write = 1'b0;
    logic [63:0] m_data  = '0;
    logic [4:0]  m_addr  = '0;
    logic        m_ovf   = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ext_model(input logic [63:0] d, input logic [2:0] f3,
                                              input logic [2:0] lo);
`ifdef WB_LOAD_EXT_EN
        logic [63:0] s;
        s = d >> (8 * lo);
        case (f3)
            3'd0: return 64'($signed(s[7:0]));
            3'd1: return 64'($signed(s[15:0]));
            3'd2: return 64'($signed(s[31:0]));
            3'd4: return 64'(s[7:0]);
            3'd5: return 64'(s[15:0]);
            3'd6: return 64'(s[31:0]);
            default: return s;
        endcase
`else
        if (f3 == 3'd7 && lo == 3'd7) return d;
        return d;
`endif
    endfunction

    task automatic set_inputs(input logic av, input logic awe, input logic [63:0] ad,
                              input logic [4:0] ard, input logic mv, input logic [63:0] md,
                              input logic [4:0] mrd, input logic [2:0] f3, input logic [2:0] lo,
                              input logic [4:0] crd);
        bus.alu_valid   = av;
        bus.alu_we      = awe;
        bus.alu_data    = ad;
        bus.alu_rd      = ard;
        bus.mem_valid   = mv;
        bus.mem_data    = md;
        bus.mem_rd      = mrd;
        bus.mem_funct3  = f3;
        bus.mem_addr_lo = lo;
        bus.check_rd    = crd;
    endtask

    task automatic check_outputs();
        chk("op_write", 64'(bus.op_write), 64'(m_write));
        chk("write_addr", 64'(bus.write_addr), 64'(m_addr));
        chk("write_data", bus.write_data, m_data);
        chk("fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
        chk("overflow_err", 64'(bus.overflow_err), 64'(m_ovf));
    endtask

    // One clock cycle: apply inputs, check the probes, then check the write port after the edge.
    task automatic step(input logic av, input logic awe, input logic [63:0] ad,
                        input logic [4:0] ard, input logic mv, input logic [63:0] md,
                        input logic [4:0] mrd, input logic [2:0] f3, input logic [2:0] lo,
                        input logic [4:0] crd);
        bit          alu_w, ready, draining, hit, acc;
        logic [63:0] ld;
        ent_t        e;
        @(negedge clk);
        set_inputs(av, awe, ad, ard, mv, md, mrd, f3, lo, crd);
        #1;
        alu_w    = av && awe && (ard != 0);
        ready    = mq.size() < DEPTH;
        draining = !alu_w && mq.size() != 0;
        hit      = 1'b0;
        for (int i = (draining ? 1 : 0); i < mq.size(); i++)
            if (mq[i].rd == crd && crd != 0) hit = 1'b1;
        chk("mem_ready", 64'(bus.mem_ready), 64'(ready));
        chk("check_hit", 64'(bus.check_hit), 64'(hit));
        @(posedge clk);
        acc = mv && ready && (mrd != 0);
        if (mv && !ready) m_ovf = 1'b1;
        ld      = ext_model(md, f3, lo);
        m_write = 1'b1;
        if (alu_w) begin
            m_addr = ard;
            m_data = ad;
            if (acc) mq.push_back('{rd: mrd, data: ld});
        end else if (mq.size() != 0) begin
            e      = mq.pop_front();
            m_addr = e.rd;
            m_data = e.data;
            if (acc) mq.push_back('{rd: mrd, data: ld});
        end else if (acc) begin
            m_addr = mrd;
            m_data = ld;
        end else begin
            m_write = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic [4:0] crd);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, crd);
    endtask

    task automatic model_reset();
        mq.delete();
        m_write = 1'b0;
        m_data  = '0;
        m_addr  = '0;
        m_ovf   = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_lb, exp_lbu;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_mem_ready", 64'(bus.mem_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        idle(0);
        chk("idle_op_write", 64'(bus.op_write), 64'd0);

        // ALU write together with a load: load queues behind it, then drains
        step(1, 1, 64'h1234, 5, 1, 64'hAA, 7, 3'b011, 0, 0);
        chk("alu_first_addr", 64'(bus.write_addr), 64'd5);
        chk("alu_first_data", bus.write_data, 64'h1234);
        chk("alu_first_count", 64'(bus.fifo_count), 64'd1);
        idle(0);
        chk("load_second_addr", 64'(bus.write_addr), 64'd7);
        chk("load_second_data", bus.write_data, 64'hAA);
        chk("load_second_count", 64'(bus.fifo_count), 64'd0);

        // Hazard probe on a queued rd=9
        step(1, 1, 64'h3, 3, 1, 64'h99, 9, 3'b011, 0, 0);
        step(1, 1, 64'h4, 4, 0, 0, 0, 0, 0, 9);
        chk("hit_rd9", 64'(bus.check_hit), 64'd1);
        step(1, 1, 64'h5, 4, 0, 0, 0, 0, 0, 0);
        chk("hit_rd0", 64'(bus.check_hit), 64'd0);
        step(1, 1, 64'h6, 4, 0, 0, 0, 0, 0, 8);
        chk("hit_rd8", 64'(bus.check_hit), 64'd0);
        idle(9);
        chk("drain_rd9_addr", 64'(bus.write_addr), 64'd9);
        idle(9);
        chk("hit_after_drain", 64'(bus.check_hit), 64'd0);

        // Fill the queue under continuous ALU writes; the fifth load overflows
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 64'(100 + i), 5'(10 + i), 1, 64'(i + 1), 5'(i + 1), 3'b011, 0, 0);
            if (i == 3) chk("full_mem_ready", 64'(bus.mem_ready), 64'd0);
        end
        chk("overflow_set", 64'(bus.overflow_err), 64'd1);
        for (int i = 0; i < 4; i++) begin
            idle(0);
            chk("drain_order", 64'(bus.write_addr), 64'(i + 1));
        end

        // Discarded writes
        step(1, 1, 64'h55, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 64'h66, 5, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 64'h77, 0, 3'b011, 0, 0);
        chk("discard_op_write", 64'(bus.op_write), 64'd0);
        chk("discard_count", 64'(bus.fifo_count), 64'd0);

        // Asynchronous reset with three queued entries
        for (int i = 0; i < 3; i++)
            step(1, 1, 64'(200 + i), 5'(i + 1), 1, 64'(300 + i), 5'(i + 4), 3'b011, 0, 0);
        chk("pre_reset_count", 64'(bus.fifo_count), 64'd3);
        @(negedge clk);
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_count", 64'(bus.fifo_count), 64'd0);
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        idle(0);
        idle(0);
        chk("post_reset_quiet", 64'(bus.op_write), 64'd0);

        // Load extension on the bypass path
`ifdef WB_LOAD_EXT_EN
        exp_lb  = 64'hFFFF_FFFF_FFFF_FFF0;
        exp_lbu = 64'h0000_0000_0000_00F0;
`else
        exp_lb  = 64'h0000_0000_0000_F080;
        exp_lbu = 64'h0000_0000_0000_F080;
`endif
        step(0, 0, 0, 0, 1, 64'h0000_0000_0000_F080, 6, 3'b000, 3'd1, 0);
        chk("ext_lb", bus.write_data, exp_lb);
        step(0, 0, 0, 0, 1, 64'h0000_0000_0000_F080, 6, 3'b100, 3'd1, 0);
        chk("ext_lbu", bus.write_data, exp_lbu);

        // Randomized traffic with bursts of ALU pressure
        for (int i = 0; i < 400; i++) begin
            int          alu_pct;
            logic [63:0] ad, md;
            alu_pct = ((i / 40) % 2 == 0) ? 85 : 25;
            ad = {$urandom, $urandom};
            md = {$urandom, $urandom};
            step($urandom_range(0, 99) < alu_pct, $urandom_range(0, 9) != 0, ad,
                 5'($urandom_range(0, 31)), $urandom_range(0, 99) < 60, md,
                 5'($urandom_range(0, 7)), 3'($urandom), 3'($urandom),
                 5'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
